if_stage_ctrl: RTL and testbench

- Fetch-stage controller and IF/ID pipeline register for the 16-bit pipelined core.
- Owns the PC and drives the instruction memory address.
- Latches fetched instructions into IF/ID and exports the rd/rs/rt fields that the hazard detection unit compares against in-flight destinations.
- Consumes the hazard unit's stall request and the EX-stage branch redirect; halts fetch on HLT.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/if_id_reg.sv | 44 ++++
 rtl/if_stage_ctrl.sv | 109 ++++++++++
 tb/tb_if_stage_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined core: instruction encodings,
// field positions and the fetch-stage state type.
package cpu_pkg;

    localparam int unsigned DEF_ADDR_W  = 16;
    localparam int unsigned DEF_INSTR_W = 16;

    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam logic [3:0]  OP_HLT    = 4'hF;

    localparam int unsigned OP_MSB = 15;
    localparam int unsigned OP_LSB = 12;
    localparam int unsigned RD_MSB = 11;
    localparam int unsigned RD_LSB = 8;
    localparam int unsigned RS_MSB = 7;
    localparam int unsigned RS_LSB = 4;
    localparam int unsigned RT_MSB = 3;
    localparam int unsigned RT_LSB = 0;

    typedef enum logic [0:0] {
        RUN,
        HALTED
    } if_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush inserts a bubble and wins over hold;
// hold freezes the whole stage.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               hold,
    input  logic [INSTR_W-1:0] fetch_instr,
    input  logic [ADDR_W-1:0]  fetch_pc_plus1,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc_plus1,
    output logic               valid
);

    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_plus1_q;
    logic               valid_q;

    // pc_plus1 is left untouched by a flush; it is meaningless while valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= INSTR_W'(NOP_INSTR);
            pc_plus1_q <= '0;
            valid_q    <= 1'b0;
        end else if (flush) begin
            instr_q <= INSTR_W'(NOP_INSTR);
            valid_q <= 1'b0;
        end else if (!hold) begin
            instr_q    <= fetch_instr;
            pc_plus1_q <= fetch_pc_plus1;
            valid_q    <= 1'b1;
        end
    end

    assign instr    = instr_q;
    assign pc_plus1 = pc_plus1_q;
    assign valid    = valid_q;

endmodule

// File: rtl/if_stage_ctrl.sv
// Fetch-stage controller: owns the PC, run/halt FSM and hazard stall counter,
// and feeds the IF/ID register.
module if_stage_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned      ADDR_W   = DEF_ADDR_W,
    parameter int unsigned      INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hazard,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] IF_ID_instr,
    output logic [ADDR_W-1:0]  IF_ID_pc_plus1,
    output logic               IF_ID_valid,
    output logic [3:0]         IF_ID_reg_rd,
    output logic [3:0]         IF_ID_reg_rs,
    output logic [3:0]         IF_ID_reg_rt,
    output logic               halted,
    output logic [7:0]         stall_cnt
);

    if_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_plus1;
    logic [7:0]        stall_cnt_q, stall_cnt_d;
    logic              is_hlt, run_fetch, run_stall;
    logic              ifid_flush, ifid_hold;

    assign is_hlt    = imem_rdata[OP_MSB:OP_LSB] == OP_HLT;
    assign pc_plus1  = pc_q + ADDR_W'(1);
    assign run_stall = (state_q == RUN) && hazard && !branch_taken;
    assign run_fetch = (state_q == RUN) && !hazard && !branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (branch_taken) begin
            state_d = RUN;
        end else if (run_fetch && is_hlt) begin
            state_d = HALTED;
        end
    end

    always_comb begin
        halted     = state_q == HALTED;
        ifid_flush = branch_taken || (state_q == HALTED);
        ifid_hold  = run_stall;
    end

    // A fetched HLT is latched into IF/ID but the PC stays on it.
    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = branch_target;
        end else if (run_fetch && !is_hlt) begin
            pc_d = pc_plus1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (run_stall && stall_cnt_q != 8'hFF) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            stall_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (ifid_flush),
        .hold           (ifid_hold),
        .fetch_instr    (imem_rdata),
        .fetch_pc_plus1 (pc_plus1),
        .instr          (IF_ID_instr),
        .pc_plus1       (IF_ID_pc_plus1),
        .valid          (IF_ID_valid)
    );

    assign imem_addr    = pc_q;
    assign stall_cnt    = stall_cnt_q;
    assign IF_ID_reg_rd = IF_ID_instr[RD_MSB:RD_LSB];
    assign IF_ID_reg_rs = IF_ID_instr[RS_MSB:RS_LSB];
    assign IF_ID_reg_rt = IF_ID_instr[RT_MSB:RT_LSB];

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Bench for if_stage_ctrl: directed scenarios plus randomized traffic against
// a behavioural model of the fetch stage.
module tb_if_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hazard;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_rdata;
    logic [15:0] imem_addr;
    logic [15:0] IF_ID_instr;
    logic [15:0] IF_ID_pc_plus1;
    logic        IF_ID_valid;
    logic [3:0]  IF_ID_reg_rd;
    logic [3:0]  IF_ID_reg_rs;
    logic [3:0]  IF_ID_reg_rt;
    logic        halted;
    logic [7:0]  stall_cnt;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int          m_pc, m_pc1, m_cnt;
    logic [15:0] m_instr;
    logic        m_valid, m_halted;

    if_stage_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hazard         (hazard),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_rdata     (imem_rdata),
        .imem_addr      (imem_addr),
        .IF_ID_instr    (IF_ID_instr),
        .IF_ID_pc_plus1 (IF_ID_pc_plus1),
        .IF_ID_valid    (IF_ID_valid),
        .IF_ID_reg_rd   (IF_ID_reg_rd),
        .IF_ID_reg_rs   (IF_ID_reg_rs),
        .IF_ID_reg_rt   (IF_ID_reg_rt),
        .halted         (halted),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 0; m_pc1 = 0; m_cnt = 0;
        m_instr = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model on the edge, settle #1 after it.
    task automatic step(input logic h, input logic b, input logic [15:0] tg,
                        input logic [15:0] rd);
        hazard = h; branch_taken = b; branch_target = tg; imem_rdata = rd;
        @(posedge clk);
        if (b) begin
            m_pc = tg; m_instr = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
        end else if (m_halted) begin
            m_instr = 16'h0000; m_valid = 1'b0;
        end else if (h) begin
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end else begin
            m_instr = rd; m_valid = 1'b1; m_pc1 = (m_pc + 1) % 65536;
            if (rd[15:12] == 4'hF) m_halted = 1'b1;
            else m_pc = (m_pc + 1) % 65536;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hazard = 0; branch_taken = 0; branch_target = 0; imem_rdata = 16'h1234;
        model_reset();
        #2;
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h want=0000", imem_addr); end
        total++; if (IF_ID_instr !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h want=0000", IF_ID_instr); end
        total++; if (IF_ID_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", IF_ID_valid); end
        total++; if (IF_ID_pc_plus1 !== 16'h0000) begin bad++; $display("FAIL reset_pc1 got=%h want=0000", IF_ID_pc_plus1); end
        total++; if (halted !== 1'b0 || stall_cnt !== 8'h00) begin bad++; $display("FAIL reset_halt_cnt got=%b/%h want=0/00", halted, stall_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL fetch_addr0 got=%h want=0000", imem_addr); end
        step(0, 0, 16'h0, 16'h1234);
        total++; if (imem_addr !== 16'h0001) begin bad++; $display("FAIL fetch_addr1 got=%h want=0001", imem_addr); end
        total++; if (IF_ID_instr !== 16'h1234 || IF_ID_valid !== 1'b1) begin bad++; $display("FAIL fetch_instr got=%h/%b want=1234/1", IF_ID_instr, IF_ID_valid); end
        total++; if ({IF_ID_reg_rd, IF_ID_reg_rs, IF_ID_reg_rt} !== 12'h234) begin bad++; $display("FAIL fetch_fields got=%h want=234", {IF_ID_reg_rd, IF_ID_reg_rs, IF_ID_reg_rt}); end
        total++; if (IF_ID_pc_plus1 !== 16'h0001) begin bad++; $display("FAIL fetch_pc1 got=%h want=0001", IF_ID_pc_plus1); end
        step(0, 0, 16'h0, 16'h1234);
        total++; if (imem_addr !== 16'h0002) begin bad++; $display("FAIL fetch_addr2 got=%h want=0002", imem_addr); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 16'h0, 16'h7777);
            total++; if (imem_addr !== 16'h0005 || IF_ID_instr !== 16'h1234) begin bad++; $display("FAIL stall_hold got=%h/%h want=0005/1234", imem_addr, IF_ID_instr); end
        end
        total++; if (stall_cnt !== 8'd3) begin bad++; $display("FAIL stall_cnt got=%0d want=3", stall_cnt); end
        step(0, 0, 16'h0, 16'h5abc);
        total++; if (imem_addr !== 16'h0006 || IF_ID_instr !== 16'h5abc || IF_ID_pc_plus1 !== 16'h0006) begin
            bad++; $display("FAIL stall_resume got=%h/%h/%h want=0006/5abc/0006", imem_addr, IF_ID_instr, IF_ID_pc_plus1); end
    endtask

    task automatic test_branch_hazard();
        step(1, 1, 16'h0040, 16'h1234);
        total++; if (imem_addr !== 16'h0040) begin bad++; $display("FAIL br_addr got=%h want=0040", imem_addr); end
        total++; if (IF_ID_valid !== 1'b0 || IF_ID_instr !== 16'h0000) begin bad++; $display("FAIL br_flush got=%b/%h want=0/0000", IF_ID_valid, IF_ID_instr); end
        total++; if (stall_cnt !== 8'd3) begin bad++; $display("FAIL br_cnt got=%0d want=3", stall_cnt); end
    endtask

    task automatic test_halt();
        step(0, 1, 16'h0009, 16'h1234);
        step(0, 0, 16'h0, 16'hf000);
        total++; if (IF_ID_instr !== 16'hf000 || IF_ID_valid !== 1'b1) begin bad++; $display("FAIL hlt_instr got=%h/%b want=f000/1", IF_ID_instr, IF_ID_valid); end
        total++; if (halted !== 1'b1 || imem_addr !== 16'h0009) begin bad++; $display("FAIL hlt_state got=%b/%h want=1/0009", halted, imem_addr); end
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 16'h0, 16'hf000);
            total++; if (IF_ID_valid !== 1'b0 || imem_addr !== 16'h0009 || halted !== 1'b1 || stall_cnt !== 8'd3) begin
                bad++; $display("FAIL hlt_idle got=%b/%h/%b/%0d want=0/0009/1/3", IF_ID_valid, imem_addr, halted, stall_cnt); end
        end
        step(0, 1, 16'h0020, 16'hf000);
        total++; if (halted !== 1'b0 || imem_addr !== 16'h0020) begin bad++; $display("FAIL hlt_branch got=%b/%h want=0/0020", halted, imem_addr); end
        step(0, 0, 16'h0, 16'h1234);
        total++; if (imem_addr !== 16'h0021 || IF_ID_valid !== 1'b1) begin bad++; $display("FAIL hlt_resume got=%h/%b want=0021/1", imem_addr, IF_ID_valid); end
    endtask

    task automatic test_wrap();
        step(0, 1, 16'hffff, 16'h1234);
        step(0, 0, 16'h0, 16'h1234);
        total++; if (imem_addr !== 16'h0000 || IF_ID_pc_plus1 !== 16'h0000) begin bad++; $display("FAIL wrap got=%h/%h want=0000/0000", imem_addr, IF_ID_pc_plus1); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) step(1, 0, 16'h0, 16'h1234);
        total++; if (stall_cnt !== 8'hff) begin bad++; $display("FAIL sat_cnt got=%0d want=255", stall_cnt); end
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL sat_addr got=%h want=0000", imem_addr); end
    endtask

    task automatic test_random();
        logic        h, b;
        logic [15:0] tg, rd;
        for (int i = 0; i < 400; i++) begin
            h  = $urandom_range(0, 3) == 0;
            b  = $urandom_range(0, 9) == 0;
            tg = 16'($urandom);
            rd = 16'($urandom);
            if ($urandom_range(0, 11) == 0) rd[15:12] = 4'hf;
            else if (rd[15:12] == 4'hf) rd[15:12] = 4'h1;
            step(h, b, tg, rd);
            total++; if (imem_addr !== 16'(m_pc)) begin bad++; $display("FAIL rnd_addr i=%0d got=%h want=%h", i, imem_addr, 16'(m_pc)); end
            total++; if (IF_ID_instr !== m_instr || IF_ID_valid !== m_valid) begin
                bad++; $display("FAIL rnd_ifid i=%0d got=%h/%b want=%h/%b", i, IF_ID_instr, IF_ID_valid, m_instr, m_valid); end
            total++; if (IF_ID_reg_rt !== m_instr[3:0] || IF_ID_reg_rs !== m_instr[7:4] || IF_ID_reg_rd !== m_instr[11:8]) begin
                bad++; $display("FAIL rnd_fields i=%0d got=%h%h%h want=%h", i, IF_ID_reg_rd, IF_ID_reg_rs, IF_ID_reg_rt, m_instr[11:0]); end
            total++; if (IF_ID_pc_plus1 !== 16'(m_pc1)) begin bad++; $display("FAIL rnd_pc1 i=%0d got=%h want=%h", i, IF_ID_pc_plus1, 16'(m_pc1)); end
            total++; if (halted !== m_halted || stall_cnt !== 8'(m_cnt)) begin
                bad++; $display("FAIL rnd_halt_cnt i=%0d got=%b/%0d want=%b/%0d", i, halted, stall_cnt, m_halted, m_cnt); end
        end
    endtask

    task automatic test_async_reset();
        step(0, 1, 16'h0100, 16'h1234);
        step(0, 0, 16'h0, 16'habcd);
        step(1, 0, 16'h0, 16'h1234);
        step(1, 0, 16'h0, 16'h1234);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total++; if (imem_addr !== 16'(m_pc) || IF_ID_instr !== m_instr || IF_ID_pc_plus1 !== 16'(m_pc1)) begin
            bad++; $display("FAIL arst_regs got=%h/%h/%h want=0000/0000/0000", imem_addr, IF_ID_instr, IF_ID_pc_plus1); end
        total++; if (IF_ID_valid !== 1'b0 || halted !== 1'b0 || stall_cnt !== 8'h00) begin
            bad++; $display("FAIL arst_flags got=%b/%b/%0d want=0/0/0", IF_ID_valid, halted, stall_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(0, 0, 16'h0, 16'h4321);
        total++; if (imem_addr !== 16'h0001 || IF_ID_instr !== 16'h4321) begin bad++; $display("FAIL arst_restart got=%h/%h want=0001/4321", imem_addr, IF_ID_instr); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_branch_hazard();
        test_halt();
        test_wrap();
        test_saturate();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
